// File: rtl/fizzbuzz_pkg.sv
// Shared types, ASCII constants and helpers for the fizzbuzz text formatter.
// FSM states, the "FizzBuzz" word table and the decimal digit-count function live here.
package fizzbuzz_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WORD   = 3'd1,
    CONV   = 3'd2,
    DIGITS = 3'd3,
    TERM   = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_I  = 8'h69;
  localparam logic [7:0] ASCII_Z  = 8'h7A;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_U  = 8'h75;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // "FizzBuzz" laid out as one 8-entry table; "Fizz" is 0..3, "Buzz" is 4..7.
  localparam logic [2:0] WORD_FIZZ_FIRST = 3'd0;
  localparam logic [2:0] WORD_BUZZ_FIRST = 3'd4;
  localparam logic [2:0] WORD_FIZZ_LAST  = 3'd3;
  localparam logic [2:0] WORD_BUZZ_LAST  = 3'd7;

  function automatic logic [7:0] f_word_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return ASCII_F;
      3'd1:    return ASCII_I;
      3'd4:    return ASCII_B;
      3'd5:    return ASCII_U;
      default: return ASCII_Z;
    endcase
  endfunction

  function automatic int f_num_digits(input int n);
    int d;
    int v;
    d = 1;
    v = n;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/fizzbuzz_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// The first bit is consumed on the start cycle, so a conversion occupies exactly W cycles.
module fizzbuzz_bin2bcd #(
  parameter int W        = 5,
  parameter int g_digits = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [W-1:0]          i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*g_digits-1:0] o_bcd
);

  localparam int BW = 4 * g_digits;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [BW-1:0] bcd;
  logic [BW-1:0] adj;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < g_digits; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_start) begin
        bcd   <= {{(BW-1){1'b0}}, i_bin[W-1]};
        shreg <= i_bin << 1;
        cnt   <= CW'(1);
        busy  <= (W > 1);
        done  <= (W == 1);
      end else if (busy) begin
        // Digits above BW are dropped, so oversized inputs wrap modulo 10**g_digits.
        bcd   <= {adj[BW-2:0], shreg[W-1]};
        shreg <= shreg << 1;
        cnt   <= cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = busy;
  assign o_done = done;
  assign o_bcd  = bcd;

endmodule

// File: rtl/fizzbuzz_formatter.sv
// Serialises {number, fizz, buzz} records as ASCII lines on a valid/ready byte stream.
// Define FIZZBUZZ_FMT_CRLF_EN to end lines with CR LF instead of LF alone.
module fizzbuzz_formatter
  import fizzbuzz_pkg::*;
#(
  parameter int  g_length = 20,
  localparam int W        = (g_length > 2) ? $clog2(g_length) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_is_fizz,
  input  logic         i_is_buzz,
  input  logic [W-1:0] i_number,
  output logic [7:0]   o_char,
  output logic         o_char_valid,
  input  logic         i_char_ready,
  output logic [2:0]   o_dbg_state,
  output logic         o_dbg_conv_busy
);

  localparam int g_digits = f_num_digits(g_length - 1);
  localparam int DW       = (g_digits > 1) ? $clog2(g_digits) : 1;
  localparam int BW       = 4 * g_digits;

  // Handshakes: a record is taken when i_valid && o_ready at a rising edge; a byte
  // moves when o_char_valid && i_char_ready. Once raised, o_char_valid and o_char
  // stay unchanged until the byte moves (only reset can withdraw them).
  state_t        state, state_nxt;
  logic          is_buzz_q;
  logic [2:0]    word_idx, word_idx_nxt;
  logic [DW-1:0] dig_idx, dig_idx_nxt, msd;
  logic [BW-1:0] bcd, bcd_shifted;
  logic [3:0]    cur_digit;
  logic          bcd_done;
  logic          accept;
`ifdef FIZZBUZZ_FMT_CRLF_EN
  logic          term_idx, term_idx_nxt;
`endif

  assign o_ready         = (state == IDLE) && !i_rst;
  assign accept          = i_valid && o_ready;
  assign o_dbg_state     = state;

  fizzbuzz_bin2bcd #(
    .W        (W),
    .g_digits (g_digits)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (accept && !i_is_fizz && !i_is_buzz),
    .i_bin   (i_number),
    .o_busy  (o_dbg_conv_busy),
    .o_done  (bcd_done),
    .o_bcd   (bcd)
  );

  // Highest non-zero digit; stays 0 for value 0 so a single '0' is printed.
  always_comb begin
    msd = '0;
    for (int d = 0; d < g_digits; d++) begin
      if (bcd[4*d +: 4] != 4'd0) msd = DW'(d);
    end
  end

  assign bcd_shifted = bcd >> {dig_idx, 2'b00};
  assign cur_digit   = bcd_shifted[3:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      is_buzz_q <= 1'b0;
      word_idx  <= '0;
      dig_idx   <= '0;
`ifdef FIZZBUZZ_FMT_CRLF_EN
      term_idx  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
      dig_idx  <= dig_idx_nxt;
`ifdef FIZZBUZZ_FMT_CRLF_EN
      term_idx <= term_idx_nxt;
`endif
      if (accept) is_buzz_q <= i_is_buzz;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    dig_idx_nxt  = dig_idx;
    o_char       = 8'h00;
    o_char_valid = 1'b0;
`ifdef FIZZBUZZ_FMT_CRLF_EN
    term_idx_nxt = term_idx;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = (i_is_fizz || i_is_buzz) ? WORD : CONV;
          word_idx_nxt = i_is_fizz ? WORD_FIZZ_FIRST : WORD_BUZZ_FIRST;
        end
      end
      WORD: begin
        o_char       = f_word_char(word_idx);
        o_char_valid = 1'b1;
        if (i_char_ready) begin
          if (word_idx == (is_buzz_q ? WORD_BUZZ_LAST : WORD_FIZZ_LAST)) state_nxt = TERM;
          else word_idx_nxt = word_idx + 3'd1;
        end
      end
      CONV: begin
        if (bcd_done) begin
          state_nxt   = DIGITS;
          dig_idx_nxt = msd;
        end
      end
      DIGITS: begin
        o_char       = ASCII_0 + {4'h0, cur_digit};
        o_char_valid = 1'b1;
        if (i_char_ready) begin
          if (dig_idx == '0) state_nxt = TERM;
          else dig_idx_nxt = dig_idx - DW'(1);
        end
      end
      TERM: begin
        o_char_valid = 1'b1;
`ifdef FIZZBUZZ_FMT_CRLF_EN
        o_char = term_idx ? ASCII_LF : ASCII_CR;
        if (i_char_ready) begin
          term_idx_nxt = !term_idx;
          if (term_idx) state_nxt = IDLE;
        end
`else
        o_char = ASCII_LF;
        if (i_char_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fizzbuzz_formatter.sv
// Self-checking bench for fizzbuzz_formatter: vector table, hand-written corner sequences
// and randomized records with downstream backpressure against a text-level reference model.
module tb_fizzbuzz_formatter;
  import fizzbuzz_pkg::*;

  localparam int G_LENGTH = 20;
  localparam int W        = $clog2(G_LENGTH);
  localparam int NUM_MOD  = 100;
`ifdef FIZZBUZZ_FMT_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 1;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_is_fizz = 1'b0;
  logic         i_is_buzz = 1'b0;
  logic [W-1:0] i_number = '0;
  logic         i_char_ready = 1'b1;
  logic         o_ready;
  logic [7:0]   o_char;
  logic         o_char_valid;
  logic [2:0]   o_dbg_state;
  logic         o_dbg_conv_busy;

  fizzbuzz_formatter #(.g_length(G_LENGTH)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_is_fizz       (i_is_fizz),
    .i_is_buzz       (i_is_buzz),
    .i_number        (i_number),
    .o_char          (o_char),
    .o_char_valid    (o_char_valid),
    .i_char_ready    (i_char_ready),
    .o_dbg_state     (o_dbg_state),
    .o_dbg_conv_busy (o_dbg_conv_busy)
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         xfer_cyc_q[$];
  int         hold_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  int         n_total = 0;
  int         n_bad = 0;

  // Monitor: collects transferred bytes and watches hold-while-stalled behaviour.
  always @(negedge i_clk) begin
    if (prev_stall && !i_rst && (!o_char_valid || o_char != prev_char)) hold_err++;
    prev_stall = !i_rst && o_char_valid && !i_char_ready;
    prev_char  = o_char;
    if (!i_rst && o_char_valid && i_char_ready) begin
      got_q.push_back(o_char);
      xfer_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: the line text for a record, from the rules alone.
  function automatic string model_text(input int n, input bit f, input bit b);
    if (f && b) return "FizzBuzz";
    if (f) return "Fizz";
    if (b) return "Buzz";
    return $sformatf("%0d", n % NUM_MOD);
  endfunction

  task automatic push_text(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_term();
`ifdef FIZZBUZZ_FMT_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  // Driver: waits (bounded) for o_ready, presents one record, returns the accept edge.
  task automatic send_record(input int n, input bit f, input bit b, output int acc);
    int guard;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(posedge i_clk); #1;
      guard++;
    end
    check("accept_ready", o_ready, 1);
    i_number  = W'(n);
    i_is_fizz = f;
    i_is_buzz = b;
    i_valid   = 1'b1;
    @(posedge i_clk);
    acc = cyc;
    #1;
    i_valid = 1'b0;
  endtask

  // Wait until every expected byte has arrived, then compare and clear the scoreboard.
  task automatic drain(input bit bp, input string name);
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 1000) begin
      if (bp) i_char_ready = ($urandom_range(0, 3) != 0);
      @(posedge i_clk); #1;
      guard++;
    end
    i_char_ready = 1'b1;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    check({name, "_n_bytes"}, got_q.size(), exp_q.size());
    check({name, "_idle"}, o_ready, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  typedef struct {
    int          num;
    logic        fz;
    logic        bz;
    logic [63:0] txt;
    int          len;
    int          lat;
  } vec_t;

  vec_t vecs[10];
  int   acc;
  int   acc_arr[4];
  int   last_idx;
  int   guard;
  int   rn;
  bit   rf, rb, rbp;

  initial begin
    vecs[0] = '{7,  1'b0, 1'b0, 64'("7"),        1, W + 1};
    vecs[1] = '{15, 1'b1, 1'b1, 64'("FizzBuzz"), 8, 1};
    vecs[2] = '{3,  1'b1, 1'b0, 64'("Fizz"),     4, 1};
    vecs[3] = '{10, 1'b0, 1'b1, 64'("Buzz"),     4, 1};
    vecs[4] = '{19, 1'b0, 1'b0, 64'("19"),       2, W + 1};
    vecs[5] = '{0,  1'b0, 1'b0, 64'("0"),        1, W + 1};
    vecs[6] = '{4,  1'b0, 1'b0, 64'("4"),        1, W + 1};
    vecs[7] = '{31, 1'b0, 1'b0, 64'("31"),       2, W + 1};
    vecs[8] = '{6,  1'b0, 1'b1, 64'("Buzz"),     4, 1};
    vecs[9] = '{12, 1'b0, 1'b0, 64'("12"),       2, W + 1};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_char_valid, 0);
    check("rst_char", o_char, 8'h00);
    check("rst_state", o_dbg_state, IDLE);
    i_rst = 1'b0;
    #1;
    check("post_rst_ready", o_ready, 1);

    // Vector table: text, byte count, first-byte latency, contiguity
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].len; i++)
        exp_q.push_back(vecs[v].txt[8*(vecs[v].len-1-i) +: 8]);
      push_term();
      xfer_cyc_q.delete();
      send_record(vecs[v].num, vecs[v].fz, vecs[v].bz, acc);
      drain(1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_count", v), xfer_cyc_q.size(), vecs[v].len + TERM_LEN);
      if (xfer_cyc_q.size() > 0) begin
        check($sformatf("vec%0d_latency", v), xfer_cyc_q[0] - acc, vecs[v].lat);
        check($sformatf("vec%0d_contig", v), xfer_cyc_q[$] - xfer_cyc_q[0],
              vecs[v].len + TERM_LEN - 1);
      end
    end

    // Back-to-back records: one idle cycle between terminator and next accept
    push_text("Fizz"); push_term();
    push_text("Buzz"); push_term();
    push_text("19");   push_term();
    push_text("0");    push_term();
    xfer_cyc_q.delete();
    send_record(3, 1'b1, 1'b0, acc_arr[0]);
    send_record(10, 1'b0, 1'b1, acc_arr[1]);
    send_record(19, 1'b0, 1'b0, acc_arr[2]);
    send_record(0, 1'b0, 1'b0, acc_arr[3]);
    drain(1'b0, "b2b");
    last_idx = 4 + TERM_LEN - 1;
    if (xfer_cyc_q.size() > last_idx) check("b2b_gap0", acc_arr[1] - xfer_cyc_q[last_idx], 1);
    last_idx = last_idx + 4 + TERM_LEN;
    if (xfer_cyc_q.size() > last_idx) check("b2b_gap1", acc_arr[2] - xfer_cyc_q[last_idx], 1);
    last_idx = last_idx + 2 + TERM_LEN;
    if (xfer_cyc_q.size() > last_idx) check("b2b_gap2", acc_arr[3] - xfer_cyc_q[last_idx], 1);

    // Stall on 'z' of "Fizz" for 5 cycles
    push_text("Fizz"); push_term();
    send_record(3, 1'b1, 1'b0, acc);
    guard = 0;
    while (!(o_char_valid && o_char == 8'h7A) && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    i_char_ready = 1'b0;
    repeat (5) begin
      @(posedge i_clk); #1;
      check("stall_char", o_char, 8'h7A);
      check("stall_valid", o_char_valid, 1);
    end
    i_char_ready = 1'b1;
    drain(1'b0, "stall");

    // Reset while the third byte of "Buzz" is presented
    push_text("Buzz"); push_term();
    send_record(10, 1'b0, 1'b1, acc);
    guard = 0;
    while (!(o_char_valid && got_q.size() == 2) && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    check("mid_third_char", o_char, 8'h7A);
    i_rst = 1'b1;
    i_char_ready = 1'b0;
    @(posedge i_clk); #1;
    check("mid_rst_valid", o_char_valid, 0);
    check("mid_rst_char", o_char, 8'h00);
    check("mid_rst_ready", o_ready, 0);
    check("mid_rst_count", got_q.size(), 2);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("mid_rst_byte%0d", i), got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
    i_rst = 1'b0;
    i_char_ready = 1'b1;
    #1;
    check("mid_rel_ready", o_ready, 1);
    push_text("7"); push_term();
    xfer_cyc_q.delete();
    send_record(7, 1'b0, 1'b0, acc);
    drain(1'b0, "after_rst");
    if (xfer_cyc_q.size() > 0) check("after_rst_latency", xfer_cyc_q[0] - acc, W + 1);

    // Randomized records with random downstream backpressure
    for (int r = 0; r < 40; r++) begin
      rn  = $urandom_range(0, (1 << W) - 1);
      rf  = $urandom_range(0, 1) == 1;
      rb  = $urandom_range(0, 1) == 1;
      rbp = $urandom_range(0, 1) == 1;
      push_text(model_text(rn, rf, rb));
      push_term();
      send_record(rn, rf, rb, acc);
      drain(rbp, $sformatf("rnd%0d", r));
    end

    check("hold_stable", hold_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
